// File: rtl/key_event_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_scheduler_if
//  Brief    : Key inputs and LED/status outputs of the key event scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface key_event_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [3:0]                  key_n;
    logic [2:0]                  led_rgb;
    logic                        busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        drop;

    modport master (output key_n, input led_rgb, busy, fifo_level, drop);
    modport slave  (input key_n, output led_rgb, busy, fifo_level, drop);
endinterface
`default_nettype wire

// File: rtl/key_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_scheduler
//  Brief    : Round-robin key press arbiter feeding an event FIFO that is
//             played back as timed RGB blink sequences.
//             Optional: KEY_SCHED_ABORT_EN makes key 3 an abort/flush key.
//  Revision : 1.0 - initial release
// ============================================================================
module key_event_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BLINK_CYCLES = 25000000,
    parameter int BLINK_COUNT  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_event_scheduler_if.slave bus
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    localparam int c_cyc_w = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int c_blk_w = $clog2(BLINK_COUNT + 1);

    localparam logic [c_lvl_w-1:0] c_depth    = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(BLINK_CYCLES - 1);
    localparam logic [c_blk_w-1:0] c_blk_last = c_blk_w'(BLINK_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ON   = 2'd2,
        S_OFF  = 2'd3
    } state_t;

    logic [3:0]         r_key_prev;
    logic               r_armed;
    logic [3:0]         w_press;
    logic [3:0]         r_pending;
    logic [1:0]         r_rr;
    logic               r_drop;
    logic               w_grant_valid;
    logic [1:0]         w_grant_id;
    logic [3:0]         w_grant_mask;
    logic               w_abort;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    logic [1:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;

    state_t             r_state;
    state_t             w_next;
    logic [c_cyc_w-1:0] r_cyc;
    logic [c_blk_w-1:0] r_blinks;
    logic               w_phase_done;
    logic [1:0]         r_id;
    logic [2:0]         r_colour;

    // The first cycle after reset only loads key_prev, so a key held low
    // across reset release is taken as already pressed rather than a new press.
    assign w_press = r_armed ? (r_key_prev & ~bus.key_n) : 4'b0000;

`ifdef KEY_SCHED_ABORT_EN
    assign w_abort = w_press[3];
`else
    assign w_abort = 1'b0;
`endif

    assign w_full       = (r_level == c_depth);
    assign w_empty      = (r_level == '0);
    assign w_push       = w_grant_valid & ~w_abort;
    assign w_grant_mask = w_grant_valid ? (4'b0001 << w_grant_id) : 4'b0000;

    // Scan downward so the nearest pending index at or after r_rr wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = r_rr;
        if (!w_full) begin
            for (int k = 3; k >= 0; k--) begin
                if (r_pending[r_rr + 2'(k)]) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = r_rr + 2'(k);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_prev <= 4'b1111;
            r_armed    <= 1'b0;
            r_pending  <= 4'b0000;
            r_rr       <= 2'd0;
            r_drop     <= 1'b0;
        end else begin
            r_key_prev <= bus.key_n;
            r_armed    <= 1'b1;
            if (w_abort) begin
                r_pending <= 4'b0000;
                r_drop    <= 1'b0;
            end else begin
                r_pending <= (r_pending & ~w_grant_mask) | (w_press & ~r_pending);
                r_drop    <= |(w_press & r_pending);
                if (w_grant_valid) begin
                    r_rr <= w_grant_id + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_phase_done = (r_cyc == c_cyc_last);
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_LOAD;
                end
            end
            S_LOAD:  w_next = S_ON;
            S_ON: begin
                if (w_phase_done) begin
                    w_next = S_OFF;
                end
            end
            S_OFF: begin
                if (w_phase_done) begin
                    w_next = (r_blinks == c_blk_last) ? S_IDLE : S_ON;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
            w_pop  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cyc    <= '0;
            r_blinks <= '0;
            r_id     <= 2'd0;
            r_colour <= 3'b000;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_id <= r_mem[r_rd_ptr];
            end
            if (r_state == S_LOAD) begin
                r_cyc    <= '0;
                r_blinks <= '0;
                case (r_id)
                    2'd0:    r_colour <= 3'b100;
                    2'd1:    r_colour <= 3'b010;
                    2'd2:    r_colour <= 3'b001;
                    default: r_colour <= 3'b111;
                endcase
            end else if (r_state == S_ON || r_state == S_OFF) begin
                r_cyc <= w_phase_done ? '0 : r_cyc + c_cyc_w'(1);
                if (r_state == S_OFF && w_phase_done) begin
                    r_blinks <= r_blinks + c_blk_w'(1);
                end
            end
        end
    end

    assign bus.led_rgb    = (r_state == S_ON) ? r_colour : 3'b000;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.fifo_level = r_level;
    assign bus.drop       = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_key_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_event_scheduler
//  Brief    : Scoreboard bench for key_event_scheduler: directed scenarios plus
//             random key activity checked against an event-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_scheduler;
    localparam int FIFO_DEPTH   = 2;
    localparam int BLINK_CYCLES = 4;
    localparam int BLINK_COUNT  = 2;
    localparam int TOTAL        = 2 * BLINK_CYCLES * BLINK_COUNT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_event_scheduler_if #(.FIFO_DEPTH(FIFO_DEPTH)) ifc ();

    key_event_scheduler #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .BLINK_CYCLES(BLINK_CYCLES),
        .BLINK_COUNT (BLINK_COUNT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int drop_seen  = 0;

    // Reference model: event-level view of pending requests, the queue and
    // the position inside the current blink sequence.
    logic [3:0] m_prev  = 4'hF;
    bit         m_armed = 1'b0;
    bit   [3:0] m_pend  = 4'h0;
    int         m_rr    = 0;
    int         m_fifo[$];
    bit         m_play  = 1'b0;
    int         m_p     = 0;
    int         m_col   = 0;
    bit         m_drop  = 1'b0;
    int         exp_q[$];
    int         obs_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int colour_of(input int id);
        case (id)
            0:       return 4;
            1:       return 2;
            2:       return 1;
            default: return 7;
        endcase
    endfunction

    function automatic int model_led();
        if (!m_play || m_p == 0) return 0;
        return (((m_p - 1) / BLINK_CYCLES) % 2 == 0) ? m_col : 0;
    endfunction

    task automatic model_reset();
        m_prev = 4'hF; m_armed = 1'b0; m_pend = 4'h0; m_rr = 0;
        m_fifo.delete(); m_play = 1'b0; m_p = 0; m_drop = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [3:0] press;
        bit   [3:0] pend_old;
        int         g;
        int         n_before;
        press   = m_armed ? (m_prev & ~ifc.key_n) : 4'h0;
        m_prev  = ifc.key_n;
        m_armed = 1'b1;
`ifdef KEY_SCHED_ABORT_EN
        if (press[3]) begin
            m_fifo.delete(); m_pend = 4'h0; m_play = 1'b0; m_p = 0;
            m_drop = 1'b0; exp_q.delete();
            return;
        end
`endif
        n_before = m_fifo.size();
        g = -1;
        if (m_pend != 0 && n_before < FIFO_DEPTH)
            for (int k = 0; k < 4; k++)
                if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        if (m_play) begin
            m_p++;
            if (m_p == TOTAL + 1) m_play = 1'b0;
        end else if (n_before > 0) begin
            m_col  = colour_of(m_fifo.pop_front());
            m_play = 1'b1;
            m_p    = 0;
            exp_q.push_back(m_col);
        end
        pend_old = m_pend;
        m_drop   = |(press & pend_old);
        m_pend   = pend_old | (press & ~pend_old);
        if (g >= 0) begin
            m_pend[g] = 1'b0;
            m_fifo.push_back(g);
            m_rr = (g + 1) % 4;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_led",   int'(ifc.led_rgb),    0);
            check("rst_busy",  int'(ifc.busy),       0);
            check("rst_level", int'(ifc.fifo_level), 0);
            check("rst_drop",  int'(ifc.drop),       0);
        end else begin
            check("led",   int'(ifc.led_rgb),    model_led());
            check("busy",  int'(ifc.busy),       int'(m_play));
            check("level", int'(ifc.fifo_level), m_fifo.size());
            check("drop",  int'(ifc.drop),       int'(m_drop));
            if (ifc.drop) drop_seen++;
        end
    end

    // Scoreboard monitor: first lit colour of each sequence is one event.
    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !ifc.busy) begin
                seen = 1'b0;
            end else if (!seen && ifc.led_rgb != 3'b000) begin
                seen = 1'b1;
                obs_q.push_back(int'(ifc.led_rgb));
                if (exp_q.size() == 0) check("sb_extra_event", exp_q.size(), 1);
                else                   check("sb_colour", int'(ifc.led_rgb), exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_keys(input logic [3:0] mask);
        ifc.key_n = ifc.key_n & ~mask;
        tick(1);
        ifc.key_n = ifc.key_n | mask;
    endtask

    task automatic do_reset();
        ifc.key_n = 4'hF;
        rst_n = 1'b0;
        tick(2);
        #2 rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        int d0;
        int quiet;
        ifc.key_n = 4'hF;
        rst_n = 1'b0;
        tick(3);
        check("reset_led",   int'(ifc.led_rgb),    0);
        check("reset_busy",  int'(ifc.busy),       0);
        check("reset_level", int'(ifc.fifo_level), 0);
        #2 rst_n = 1'b1;
        tick(3);

        // Single press: key driven low just after edge E, lit from edge E+4.
        ifc.key_n = 4'b1110;
        tick(2);
        check("single_level_peak", int'(ifc.fifo_level), 1);
        ifc.key_n = 4'hF;
        tick(1);
        check("single_load_led",  int'(ifc.led_rgb), 0);
        check("single_load_busy", int'(ifc.busy),    1);
        tick(1);
        check("single_first_on", int'(ifc.led_rgb), 3'b100);
        tick(15);
        check("single_last_off_busy", int'(ifc.busy),    1);
        check("single_last_off_led",  int'(ifc.led_rgb), 0);
        tick(1);
        check("single_busy_fall", int'(ifc.busy), 0);
        tick(4);

        // Simultaneous press of all keys from rr_ptr=0.
        do_reset();
        obs_q.delete();
        d0 = drop_seen;
        press_keys(4'b1111);
        tick(90);
        check("simul_count", obs_q.size(), 4);
        check("simul_ord0", obs_q[0], 4);
        check("simul_ord1", obs_q[1], 2);
        check("simul_ord2", obs_q[2], 1);
        check("simul_ord3", obs_q[3], 7);
        check("simul_drops", drop_seen - d0, 0);

        // Round-robin rotation after serving key 1.
        do_reset();
        press_keys(4'b0010);
        tick(TOTAL + 6);
        obs_q.delete();
        press_keys(4'b0101);
        tick(45);
        check("rr_count",  obs_q.size(), 2);
        check("rr_first",  obs_q[0], 1);
        check("rr_second", obs_q[1], 4);

        // Duplicate press of key 1 while the queue is full.
        do_reset();
        obs_q.delete();
        d0 = drop_seen;
        press_keys(4'b1101);
        tick(4);
        press_keys(4'b0010);
        tick(2);
        press_keys(4'b0010);
        tick(85);
        check("dup_drops", drop_seen - d0, 1);
        check("dup_count", obs_q.size(), 4);
        check("dup_ord3",  obs_q[3], 2);

        // Reset during the ON phase of key 2, key 1 held through release.
        do_reset();
        press_keys(4'b0100);
        tick(1);
        press_keys(4'b0001);
        tick(3);
        check("midon_busy_before", int'(ifc.busy),    1);
        check("midon_led_before",  int'(ifc.led_rgb), 3'b001);
        ifc.key_n = 4'b1101;
        rst_n = 1'b0;
        #1;
        check("midon_led",   int'(ifc.led_rgb),    0);
        check("midon_busy",  int'(ifc.busy),       0);
        check("midon_level", int'(ifc.fifo_level), 0);
        tick(2);
        #2 rst_n = 1'b1;
        tick(10);
        check("held_busy",  int'(ifc.busy),       0);
        check("held_level", int'(ifc.fifo_level), 0);
        ifc.key_n = 4'hF;
        tick(5);

`ifdef KEY_SCHED_ABORT_EN
        do_reset();
        press_keys(4'b0001);
        press_keys(4'b0110);
        tick(4);
        check("abort_pre_led",   int'(ifc.led_rgb),    3'b100);
        check("abort_pre_level", int'(ifc.fifo_level), 2);
        press_keys(4'b1000);
        check("abort_level", int'(ifc.fifo_level), 0);
        check("abort_led",   int'(ifc.led_rgb),    0);
        check("abort_busy",  int'(ifc.busy),       0);
        tick(30);
`endif

        // Random key activity.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 >= 340) ifc.key_n = 4'hF;
            else if ($urandom_range(0, 5) == 0) ifc.key_n ^= 4'($urandom_range(1, 15));
            tick(1);
        end

        ifc.key_n = 4'hF;
        quiet = 0;
        for (int i = 0; i < 4000 && quiet < 5; i++) begin
            tick(1);
            if (!ifc.busy && ifc.fifo_level == 0 && m_pend == 0) quiet++;
            else quiet = 0;
        end
        check("drain_timeout", quiet, 5);
        check("sb_leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Arbitrates debounced key presses from four buttons and queues them as events.
- Plays each queued event as a timed RGB blink sequence.
- Sits between the per-key debounce stages and the board RGB LED pins, replacing direct key-to-LED toggling.
- Presses that arrive together, or while a sequence is playing, are buffered and served in order; none are silently lost.

Parameters:
- FIFO_DEPTH, 4, event queue entries; power of two, minimum 2.
- BLINK_CYCLES, 25000000, clk cycles per ON phase and per OFF phase (0.5 s at 50 MHz).
- BLINK_COUNT, 3, ON/OFF pairs per event; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- key_n  in  4  debounced keys, active-low, synchronous to clk; bit i = key i
- led_rgb  out  3  {R,G,B}, active-high
- busy  out  1  high while a sequence is playing (FSM not IDLE)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy
- drop  out  1  one-cycle pulse when a press is lost

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All state is cleared on rst_n low.
- Reset values:
  - led_rgb=000, busy=0, fifo_level=0, drop=0.
  - key_prev=4'b1111 (a key held low through reset deasserts without producing a press).
  - Pending bits=0, round-robin pointer=0, FSM=IDLE.
- Edge detect: press on key i when key_prev[i]=1 and key_n[i]=0. key_prev is registered every cycle.
- Pending: a press sets pending[i] on the next edge.
  - A press on key i while pending[i] is already 1 is lost: drop pulses 1 cycle, pending unchanged.
  - Presses on several keys in the same cycle all set their pending bits; no drop.
- Arbiter: round-robin.
  - Each cycle, if any pending bit is set and the FIFO is not full, grant the first pending index at or after rr_ptr (wrapping 3->0).
  - Push the 2-bit key id, clear that pending bit, set rr_ptr = granted+1 mod 4.
  - At most one push per cycle.
  - FIFO full: no grant, pending bits held, no drop.
- FIFO: synchronous, DEPTH entries, wrap-around pointers.
  - Push and pop in the same cycle are both allowed when non-empty; level unchanged.
  - Pop happens only from FSM IDLE.
- FSM states: IDLE, LOAD, ON, OFF.
  - IDLE: led_rgb=000, busy=0. If FIFO non-empty, pop -> LOAD.
  - LOAD: latch colour from popped id: 0->100, 1->010, 2->001, 3->111. Clear cycle counter and blink counter -> ON.
  - ON: led_rgb=colour. After BLINK_CYCLES cycles in ON -> OFF.
  - OFF: led_rgb=000. After BLINK_CYCLES cycles in OFF:
    - blink counter+1; if it equals BLINK_COUNT -> IDLE, else -> ON.
  - Each ON and OFF phase lasts exactly BLINK_CYCLES cycles.
- Latency: key_n low sampled at edge N gives:
  - pending at N+1
  - push at N+2
  - pop at N+3 (if IDLE and FIFO otherwise empty)
  - LOAD at N+3..N+4
  - led_rgb on from edge N+4
- Counters are wide enough for BLINK_CYCLES-1 and BLINK_COUNT with no overflow.
- Reset mid-sequence: LEDs go off immediately and the queue is discarded.

Optional Feature:
KEY_SCHED_ABORT_EN
- Defined:
  - A key-3 press never enters pending or the FIFO.
  - On the cycle after the press: FIFO flushed (level 0), pending bits 0..2 cleared, FSM forced to IDLE, led_rgb=000.
  - Presses on other keys in that same cycle are discarded; drop is not asserted.
- Undefined: key 3 is an ordinary requester (white blink), as specified above.

Test Plan:
All scenarios use BLINK_CYCLES=4, BLINK_COUNT=2, FIFO_DEPTH=2.
- Single press: key_n[0] low at edge 10 -> led_rgb=100 on edges 14-17, 000 on 18-21, 100 on 22-25, 000 on 26-29; busy falls at 30; fifo_level peaks at 1.
- Simultaneous press: key_n=4'b0000 at one edge, rr_ptr=0 -> FIFO order 0,1 (2 and 3 stay pending until space). Colours play 100, 010, 001, 111 in that order with no drop pulse.
- Round-robin rotation: after serving key 1, assert keys 0 and 2 together -> key 2 is pushed before key 0.
- Duplicate drop: press key 1, release, and press again before its pending bit is granted while FIFO is full -> exactly one drop pulse; key 1 plays once for that pending slot.
- Reset mid-ON: rst_n low during the ON phase of key 2 -> led_rgb=000, busy=0, fifo_level=0 in the same cycle. A key held low through reset release produces no event.
- With KEY_SCHED_ABORT_EN: queue holds 2 events and key 0 is blinking; press key 3 -> next cycle fifo_level=0, led_rgb=000, busy=0, no white blink.
